// File: rtl/pong_nios_oci_dct_monitor.sv
// Trace-capture monitor: buffers {dct_count, dct_buffer} records in a FIFO during a
// capture session, counts drops on overflow, then drains until the test has ended.
module pong_nios_oci_dct_monitor #(
  parameter  int DCT_WIDTH   = 30,
  parameter  int COUNT_WIDTH = 4,
  parameter  int DEPTH       = 16,
  localparam int AW          = $clog2(DEPTH),
  localparam int RW          = COUNT_WIDTH + DCT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   arm,
  input  logic                   dct_valid,
  input  logic [DCT_WIDTH-1:0]   dct_buffer,
  input  logic [COUNT_WIDTH-1:0] dct_count,
  input  logic                   test_ending,
  input  logic                   test_has_ended,
  input  logic                   rd_en,
  output logic [RW-1:0]          rd_data,
  output logic                   rd_valid,
  output logic [AW:0]            fill_level,
  output logic                   overflow,
  output logic [7:0]             drop_count,
  output logic [1:0]             state,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DRAIN = 2'd2, ENDED = 2'd3} st_e;

  st_e            state_q, state_d;
  logic [RW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    fill_q, fill_d;
  logic           ovf_q, rd_valid_q;
  logic [7:0]     drop_q;
  logic [RW-1:0]  rd_data_q;
  logic           full, empty, rd_acc, wr_acc, drop, start;

  always_comb begin
    full    = (fill_q == (AW+1)'(DEPTH));
    empty   = (fill_q == '0);
    rd_acc  = rd_en && !empty && (state_q != IDLE);
    // a full FIFO still takes a write when a read frees the slot in the same cycle
    wr_acc  = (state_q == CAPTURE) && dct_valid && (!full || rd_acc);
    drop    = (state_q == CAPTURE) && dct_valid && full && !rd_acc;
    start   = arm && ((state_q == IDLE) || (state_q == ENDED));
    fill_d  = fill_q;
    if (wr_acc && !rd_acc)      fill_d = fill_q + 1'b1;
    else if (rd_acc && !wr_acc) fill_d = fill_q - 1'b1;
    state_d = state_q;
    case (state_q)
      IDLE, ENDED: if (arm) state_d = CAPTURE;
      default: begin
        if (test_has_ended && (fill_d == '0))
          state_d = ENDED;
        else if ((state_q == CAPTURE) && (test_ending || test_has_ended))
          state_d = DRAIN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem[rd_ptr_q];
      if (start) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        fill_q   <= '0;
        ovf_q    <= 1'b0;
        drop_q   <= '0;
      end else begin
        if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (rd_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
        fill_q <= fill_d;
        if (drop) begin
          ovf_q <= 1'b1;
          if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
      end
    end
  end

  // storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= {dct_count, dct_buffer};
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign fill_level = fill_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
  assign state      = state_q;
  assign done       = (state_q == ENDED);

endmodule

// File: tb/tb_pong_nios_oci_dct_monitor.sv
// Bench for the DCT trace monitor: queue-based reference model checked every cycle on
// the default build, plus directed literal checks on default and a small build.
module tb_pong_nios_oci_dct_monitor;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // default build: DEPTH 16, 30-bit data, 4-bit count
  logic        arm_a = 0, dv_a = 0, te_a = 0, the_a = 0, rd_a = 0;
  logic [29:0] buf_a = '0;
  logic [3:0]  cnt_a = '0;
  logic [33:0] rdd_a;
  logic        rdv_a, ovf_a, done_a;
  logic [4:0]  fill_a;
  logic [7:0]  drop_a;
  logic [1:0]  st_a;

  // small build: DEPTH 2, 8-bit data, 2-bit count
  logic        arm_b = 0, dv_b = 0, te_b = 0, the_b = 0, rd_b = 0;
  logic [7:0]  buf_b = '0;
  logic [1:0]  cnt_b = '0;
  logic [9:0]  rdd_b;
  logic        rdv_b, ovf_b, done_b;
  logic [1:0]  fill_b;
  logic [7:0]  drop_b;
  logic [1:0]  st_b;

  pong_nios_oci_dct_monitor dut_a (
    .clk(clk), .reset_n(reset_n), .arm(arm_a), .dct_valid(dv_a), .dct_buffer(buf_a),
    .dct_count(cnt_a), .test_ending(te_a), .test_has_ended(the_a), .rd_en(rd_a),
    .rd_data(rdd_a), .rd_valid(rdv_a), .fill_level(fill_a), .overflow(ovf_a),
    .drop_count(drop_a), .state(st_a), .done(done_a));

  pong_nios_oci_dct_monitor #(.DCT_WIDTH(8), .COUNT_WIDTH(2), .DEPTH(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .arm(arm_b), .dct_valid(dv_b), .dct_buffer(buf_b),
    .dct_count(cnt_b), .test_ending(te_b), .test_has_ended(the_b), .rd_en(rd_b),
    .rd_data(rdd_b), .rd_valid(rdv_b), .fill_level(fill_b), .overflow(ovf_b),
    .drop_count(drop_b), .state(st_b), .done(done_b));

  int errors = 0;
  int checks = 0;

  // reference model of the default build
  logic [33:0] mq[$];
  int          mst = 0, mdc = 0;
  bit          mov = 0, mrv = 0;
  logic [33:0] mrd = '0;

  function automatic logic [33:0] rec(int c, int b);
    return {4'(c), 30'(b)};
  endfunction

  function automatic logic [9:0] recb(int c, int b);
    return {2'(c), 8'(b)};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rd, wr, drp;
    int n;
    if (!reset_n) begin
      mq.delete(); mst = 0; mdc = 0; mov = 0; mrv = 0; mrd = '0;
      return;
    end
    n   = mq.size();
    rd  = rd_a && n > 0 && mst != 0;
    wr  = mst == 1 && dv_a && (n < 16 || rd);
    drp = mst == 1 && dv_a && n == 16 && !rd;
    mrv = rd;
    if (rd) mrd = mq[0];
    if (arm_a && (mst == 0 || mst == 3)) begin
      mq.delete(); mov = 0; mdc = 0; mst = 1;
    end else begin
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back({cnt_a, buf_a});
      if (drp) begin
        mov = 1;
        if (mdc < 255) mdc++;
      end
      if ((mst == 1 || mst == 2) && the_a && mq.size() == 0) mst = 3;
      else if (mst == 1 && (te_a || the_a)) mst = 2;
    end
  endtask

  // one clock: advance the model on the rising edge, compare on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("m_state", st_a, mst);
    chk("m_done", done_a, mst == 3);
    chk("m_fill", fill_a, mq.size());
    chk("m_ovf", ovf_a, mov);
    chk("m_drop", drop_a, mdc);
    chk("m_rd_valid", rdv_a, mrv);
    chk("m_rd_data", rdd_a, mrd);
  endtask

  initial begin
    tick(); tick();
    chk("rst_state", st_a, 0);
    chk("rst_fill", fill_a, 0);
    chk("rst_rdv", rdv_a, 0);
    chk("rst_rdd", rdd_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_drop", drop_a, 0);
    reset_n = 1;
    tick();

    // basic three records
    arm_a = 1; tick(); arm_a = 0;
    chk("arm_state", st_a, 1);
    for (int i = 1; i <= 3; i++) begin
      dv_a = 1; cnt_a = 4'(i); buf_a = 30'(i); tick();
    end
    dv_a = 0;
    chk("basic_fill", fill_a, 3);
    rd_a = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("basic_rdv", rdv_a, 1);
      chk("basic_rdd", rdd_a, rec(i, i));
      chk("basic_fill_dn", fill_a, 3 - i);
    end
    rd_a = 0; tick();
    chk("basic_rdv_off", rdv_a, 0);

    // full FIFO with simultaneous read and write
    for (int i = 0; i < 16; i++) begin
      dv_a = 1; cnt_a = 4'(i); buf_a = 30'(200 + i); tick();
    end
    chk("full_fill", fill_a, 16);
    rd_a = 1;
    for (int i = 0; i < 5; i++) begin
      cnt_a = 4'(i); buf_a = 30'(300 + i); tick();
      chk("rw_fill", fill_a, 16);
      chk("rw_ovf", ovf_a, 0);
      chk("rw_rdd", rdd_a, rec(i, 200 + i));
    end
    dv_a = 0;
    for (int j = 0; j < 16; j++) begin
      tick();
      chk("rw_drain", rdd_a, (j < 11) ? rec(j + 5, 205 + j) : rec(j - 11, 300 + j - 11));
    end
    rd_a = 0; tick();
    chk("rw_empty", fill_a, 0);

    // overflow: 20 writes into 16 slots
    for (int i = 0; i < 20; i++) begin
      dv_a = 1; cnt_a = 4'(i); buf_a = 30'(100 + i); tick();
    end
    dv_a = 0;
    chk("ovf_fill", fill_a, 16);
    chk("ovf_flag", ovf_a, 1);
    chk("ovf_drop", drop_a, 4);
    rd_a = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("ovf_rdd", rdd_a, rec(i, 100 + i));
    end
    rd_a = 0; tick();

    // end sequence
    for (int i = 0; i < 2; i++) begin
      dv_a = 1; cnt_a = 4'(i + 1); buf_a = 30'(400 + i); tick();
    end
    te_a = 1; cnt_a = 4'd3; buf_a = 30'd402; tick();
    te_a = 0;
    chk("end_state", st_a, 2);
    chk("end_fill", fill_a, 3);
    buf_a = 30'd999; tick();
    dv_a = 0;
    chk("drain_ign_fill", fill_a, 3);
    chk("drain_ign_drop", drop_a, 4);
    the_a = 1; rd_a = 1;
    tick();
    chk("end_rd1", rdd_a, rec(1, 400));
    chk("end_st1", st_a, 2);
    tick(); tick();
    chk("end_rd3", rdd_a, rec(3, 402));
    chk("ended_state", st_a, 3);
    chk("ended_done", done_a, 1);
    the_a = 0;
    tick();
    chk("empty_rd", rdv_a, 0);
    rd_a = 0;

    // re-arm, store 5, reset between edges
    arm_a = 1; tick(); arm_a = 0;
    chk("rearm_state", st_a, 1);
    chk("rearm_drop", drop_a, 0);
    chk("rearm_ovf", ovf_a, 0);
    for (int i = 0; i < 5; i++) begin
      dv_a = 1; cnt_a = 4'(i); buf_a = 30'(600 + i); tick();
    end
    dv_a = 0;
    chk("pre_rst_fill", fill_a, 5);
    #2 reset_n = 0;
    #1;
    chk("arst_state", st_a, 0);
    chk("arst_fill", fill_a, 0);
    chk("arst_rdd", rdd_a, 0);
    chk("arst_rdv", rdv_a, 0);
    chk("arst_done", done_a, 0);
    tick();
    reset_n = 1;
    tick();
    chk("post_rst_idle", st_a, 0);
    arm_a = 1; tick(); arm_a = 0;
    dv_a = 1; cnt_a = 4'd5; buf_a = 30'd500; tick(); dv_a = 0;
    rd_a = 1; tick();
    chk("post_rst_rdv", rdv_a, 1);
    chk("post_rst_rdd", rdd_a, rec(5, 500));
    tick();
    chk("post_rst_only1", rdv_a, 0);
    rd_a = 0;

    // small build
    arm_b = 1; tick(); arm_b = 0;
    chk("b_arm", st_b, 1);
    for (int i = 1; i <= 2; i++) begin
      dv_b = 1; cnt_b = 2'(i); buf_b = 8'(i); tick();
    end
    dv_b = 0;
    chk("b_fill", fill_b, 2);
    rd_b = 1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      chk("b_rdv", rdv_b, 1);
      chk("b_rdd", rdd_b, recb(i, i));
      chk("b_fill_dn", fill_b, 2 - i);
    end
    rd_b = 0; tick();
    chk("b_rdv_off", rdv_b, 0);
    for (int i = 0; i < 260; i++) begin
      dv_b = 1; cnt_b = 2'(i); buf_b = 8'(i + 10); tick();
    end
    dv_b = 0;
    chk("b_ovf_fill", fill_b, 2);
    chk("b_ovf", ovf_b, 1);
    chk("b_drop_sat", drop_b, 255);
    rd_b = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("b_ovf_rdd", rdd_b, recb(i, i + 10));
    end
    rd_b = 0; tick();
    chk("b_empty", fill_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
